// File: rtl/final_nios2_proc_jtag_scan_driver_if.sv
// Command/response handshake plus virtual-JTAG pins of the scan driver.
// The master side is the host/target environment; the slave side is the driver.
interface final_nios2_proc_jtag_scan_driver_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_dr;
    logic [IR_WIDTH-1:0] rsp_ir_out;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic [IR_WIDTH-1:0] vji_ir_out;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;

    modport master (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        input  vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
        output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out,
        output vji_tck, vji_tdi, vji_ir_in, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti
    );
endinterface

// File: rtl/final_nios2_proc_jtag_scan_driver.sv
// Virtual-JTAG scan initiator: per command runs UIR -> CDR -> SDR x DR_WIDTH -> UDR
// with a generated TCK, shifting cmd_dr out on tdi and capturing tdo into rsp_dr.
module final_nios2_proc_jtag_scan_driver #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic clk,
    input  logic reset,
    final_nios2_proc_jtag_scan_driver_if.slave bus
);
    localparam int CW = (2 * TCK_DIV > 1) ? $clog2(2 * TCK_DIV) : 1;
    localparam int BW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOW_LAST = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(2 * TCK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST     = BW'(DR_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RESP} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bitc;
    logic [DR_WIDTH-1:0] dr_q;

    // Outputs are registered together with the state: the edge that enters a
    // period also drives that period's strobes, so TCK falls with the strobe change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bitc           <= '0;
            dr_q           <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_dr     <= '0;
            bus.rsp_ir_out <= '0;
            bus.vji_tck    <= 1'b0;
            bus.vji_tdi    <= 1'b0;
            bus.vji_ir_in  <= '0;
            bus.vji_uir    <= 1'b0;
            bus.vji_cdr    <= 1'b0;
            bus.vji_sdr    <= 1'b0;
            bus.vji_udr    <= 1'b0;
            bus.vji_rti    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        dr_q          <= bus.cmd_dr;
                        bus.vji_ir_in <= bus.cmd_ir;
                        bus.cmd_ready <= 1'b0;
                        bus.vji_rti   <= 1'b0;
                        bus.vji_uir   <= 1'b1;
                        cnt           <= '0;
                        bitc          <= '0;
                        state         <= UIR;
                    end
                end
                UIR, CDR, SDR, UDR: begin
                    // Last low-phase clk: sample the target before TCK rises.
                    if (cnt == CNT_LOW_LAST) begin
                        bus.vji_tck <= 1'b1;
                        if (state == SDR) bus.rsp_dr[bitc] <= bus.vji_tdo;
                        if (state == UDR) bus.rsp_ir_out <= bus.vji_ir_out;
                    end
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt         <= '0;
                        bus.vji_tck <= 1'b0;
                        case (state)
                            UIR: begin
                                bus.vji_uir <= 1'b0;
                                bus.vji_cdr <= 1'b1;
                                bitc        <= '0;
                                state       <= CDR;
                            end
                            CDR: begin
                                bus.vji_cdr <= 1'b0;
                                bus.vji_sdr <= 1'b1;
                                bus.vji_tdi <= dr_q[0];
                                bitc        <= '0;
                                state       <= SDR;
                            end
                            SDR: begin
                                if (bitc == BIT_LAST) begin
                                    bus.vji_sdr <= 1'b0;
                                    bus.vji_udr <= 1'b1;
                                    bus.vji_tdi <= 1'b0;
                                    bitc        <= '0;
                                    state       <= UDR;
                                end else begin
                                    bitc        <= bitc + 1'b1;
                                    dr_q        <= {1'b0, dr_q[DR_WIDTH-1:1]};
                                    bus.vji_tdi <= dr_q[1];
                                end
                            end
                            UDR: begin
                                bus.vji_udr   <= 1'b0;
                                bus.vji_rti   <= 1'b1;
                                bus.rsp_valid <= 1'b1;
                                bitc          <= '0;
                                state         <= RESP;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        cnt           <= '0;
                        bitc          <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_final_nios2_proc_jtag_scan_driver.sv
// Directed bench: loopback shift-register targets on a default driver and on a
// TCK_DIV=1 / DR_WIDTH=4 driver, vector table plus hold and mid-scan reset sequences.
module tb_final_nios2_proc_jtag_scan_driver;
    localparam int DW   = 38;
    localparam int IW   = 2;
    localparam int SDW  = 4;
    // Acceptance edge E; rsp_valid is visible in cycle E+165, i.e. after the 164th edge past E.
    localparam int LAT  = 164;
    localparam int SLAT = 14;

    logic clk = 1'b0;
    logic rst, rst_s;
    always #5 clk = ~clk;

    final_nios2_proc_jtag_scan_driver_if #(.DR_WIDTH(DW),  .IR_WIDTH(IW)) bif ();
    final_nios2_proc_jtag_scan_driver_if #(.DR_WIDTH(SDW), .IR_WIDTH(IW)) sif ();

    final_nios2_proc_jtag_scan_driver #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(2)) u_dut (
        .clk(clk), .reset(rst), .bus(bif));
    final_nios2_proc_jtag_scan_driver #(.DR_WIDTH(SDW), .IR_WIDTH(IW), .TCK_DIV(1)) u_small (
        .clk(clk), .reset(rst_s), .bus(sif));

    logic          tgt_load = 1'b0;
    logic [DW-1:0] tgt, tgt_init;
    logic [SDW-1:0] tgt_s;
    logic [IW-1:0] ir_out_val;
    int            sdr_rises, tck_rises;

    always @(posedge bif.vji_tck or posedge tgt_load) begin
        if (tgt_load) begin
            tgt       <= tgt_init;
            sdr_rises <= 0;
            tck_rises <= 0;
        end else begin
            tck_rises <= tck_rises + 1;
            if (bif.vji_sdr) begin
                tgt       <= {bif.vji_tdi, tgt[DW-1:1]};
                sdr_rises <= sdr_rises + 1;
            end
        end
    end

    always @(posedge sif.vji_tck or posedge tgt_load) begin
        if (tgt_load) tgt_s <= 4'b0110;
        else if (sif.vji_sdr) tgt_s <= {sif.vji_tdi, tgt_s[SDW-1:1]};
    end

    assign bif.vji_tdo    = tgt[0];
    assign bif.vji_ir_out = ir_out_val;
    assign sif.vji_tdo    = tgt_s[0];
    assign sif.vji_ir_out = 2'b01;

    logic mon_clr = 1'b1;
    int   n_uir, n_cdr, n_udr, n_multi;
    always @(negedge clk) begin
        if (mon_clr) begin
            n_uir <= 0; n_cdr <= 0; n_udr <= 0; n_multi <= 0;
        end else begin
            n_uir <= n_uir + int'(bif.vji_uir);
            n_cdr <= n_cdr + int'(bif.vji_cdr);
            n_udr <= n_udr + int'(bif.vji_udr);
            if ($countones({bif.vji_uir, bif.vji_cdr, bif.vji_sdr, bif.vji_udr, bif.vji_rti}) > 1)
                n_multi <= n_multi + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic load_tgt(input logic [DW-1:0] v);
        tgt_init = v;
        tgt_load = 1'b1;
        #1 tgt_load = 1'b0;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic scan_main(input logic [IW-1:0] ir, input logic [DW-1:0] dr, output int lat);
        int w;
        w = 0;
        bif.cmd_ir = ir; bif.cmd_dr = dr; bif.cmd_valid = 1'b1;
        while (!bif.cmd_ready && w < 400) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0; bif.cmd_ir = ~ir; bif.cmd_dr = ~dr;
        lat = 0;
        while (!bif.rsp_valid && lat < 400) begin @(posedge clk); #1; lat++; end
    endtask

    function automatic logic [8:0] ctl_bits();
        return {bif.cmd_ready, bif.rsp_valid, bif.vji_tck, bif.vji_tdi, bif.vji_uir,
                bif.vji_cdr, bif.vji_sdr, bif.vji_udr, bif.vji_rti};
    endfunction

    typedef struct {
        logic [DW-1:0] init;
        logic [DW-1:0] dr;
        logic [IW-1:0] ir;
        logic [IW-1:0] irout;
        logic [DW-1:0] exp_rsp;
        logic [DW-1:0] exp_tgt;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int tr0;
        int seen;
        vecs[0] = '{38'h15_5555_5555, 38'h2A_AAAA_AAAA, 2'b01, 2'b10, 38'h15_5555_5555, 38'h2A_AAAA_AAAA};
        vecs[1] = '{38'h00_0000_0000, 38'h3F_FFFF_FFFF, 2'b11, 2'b01, 38'h00_0000_0000, 38'h3F_FFFF_FFFF};
        vecs[2] = '{38'h3F_FFFF_FFFF, 38'h00_0000_0000, 2'b00, 2'b11, 38'h3F_FFFF_FFFF, 38'h00_0000_0000};
        vecs[3] = '{38'h20_0000_0001, 38'h12_3456_789A, 2'b10, 2'b00, 38'h20_0000_0001, 38'h12_3456_789A};

        rst = 1'b1; rst_s = 1'b1;
        bif.cmd_valid = 1'b0; bif.cmd_ir = '0; bif.cmd_dr = '0; bif.rsp_ready = 1'b1;
        sif.cmd_valid = 1'b0; sif.cmd_ir = '0; sif.cmd_dr = '0; sif.rsp_ready = 1'b1;
        ir_out_val = '0;
        load_tgt(38'h15_5555_5555);
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_s = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_ctl", ctl_bits(), 9'b1_0000_0001);
        chk("reset_data", {bif.rsp_dr, bif.rsp_ir_out, bif.vji_ir_in}, 64'd0);

        for (int i = 0; i < 4; i++) begin
            load_tgt(vecs[i].init);
            ir_out_val = vecs[i].irout;
            clr_mon();
            scan_main(vecs[i].ir, vecs[i].dr, lat);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk($sformatf("v%0d_rsp_dr", i), bif.rsp_dr, vecs[i].exp_rsp);
            chk($sformatf("v%0d_rsp_ir_out", i), bif.rsp_ir_out, vecs[i].irout);
            chk($sformatf("v%0d_ir_in", i), bif.vji_ir_in, vecs[i].ir);
            chk($sformatf("v%0d_target", i), tgt, vecs[i].exp_tgt);
            chk($sformatf("v%0d_sdr_tck", i), sdr_rises, DW);
            chk($sformatf("v%0d_uir_cyc", i), n_uir, 4);
            chk($sformatf("v%0d_cdr_cyc", i), n_cdr, 4);
            chk($sformatf("v%0d_udr_cyc", i), n_udr, 4);
            chk($sformatf("v%0d_overlap", i), n_multi, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_consumed", i), {bif.rsp_valid, bif.cmd_ready}, 2'b01);
            @(negedge clk);
        end

        // Response back-pressure with a new command already offered.
        load_tgt(38'h15_5555_5555);
        ir_out_val = 2'b11;
        bif.rsp_ready = 1'b0;
        scan_main(2'b10, 38'h0F_0F0F_0F0F, lat);
        chk("hold_latency", lat, LAT);
        chk("hold_rsp", bif.rsp_dr, 38'h15_5555_5555);
        bif.cmd_valid = 1'b1; bif.cmd_ir = 2'b01; bif.cmd_dr = 38'h15_5555_5555;
        tr0 = tck_rises;
        repeat (20) begin
            @(negedge clk);
            chk("hold_ready", {bif.rsp_valid, bif.cmd_ready}, 2'b10);
            chk("hold_stable", bif.rsp_dr, 38'h15_5555_5555);
        end
        chk("hold_no_tck", tck_rises - tr0, 0);
        bif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_ready", {bif.rsp_valid, bif.cmd_ready}, 2'b01);
        @(posedge clk); #1;
        chk("second_start", {bif.cmd_ready, bif.vji_uir, bif.vji_ir_in}, {1'b0, 1'b1, 2'b01});
        bif.cmd_valid = 1'b0;
        lat = 0;
        while (!bif.rsp_valid && lat < 400) begin @(posedge clk); #1; lat++; end
        chk("second_latency", lat, LAT);
        chk("second_rsp", bif.rsp_dr, 38'h0F_0F0F_0F0F);
        chk("second_ir_out", bif.rsp_ir_out, 2'b11);
        @(negedge clk);

        // Reset 60 cycles into a scan.
        load_tgt(38'h15_5555_5555);
        ir_out_val = 2'b10;
        bif.cmd_ir = 2'b11; bif.cmd_dr = 38'h2A_AAAA_AAAA; bif.cmd_valid = 1'b1;
        @(posedge clk); #1 bif.cmd_valid = 1'b0;
        repeat (59) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_ctl", ctl_bits(), 9'b1_0000_0001);
        chk("midreset_data", {bif.rsp_dr, bif.rsp_ir_out, bif.vji_ir_in}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (bif.rsp_valid) seen++;
        end
        chk("midreset_no_rsp", seen, 0);
        load_tgt(38'h3C_0000_0003);
        scan_main(2'b01, 38'h01_2345_6789, lat);
        chk("after_reset_latency", lat, LAT);
        chk("after_reset_rsp", bif.rsp_dr, 38'h3C_0000_0003);
        chk("after_reset_target", tgt, 38'h01_2345_6789);
        chk("after_reset_ir_out", bif.rsp_ir_out, 2'b10);
        @(negedge clk);

        // TCK_DIV=1, DR_WIDTH=4 driver.
        load_tgt(tgt_init);
        @(negedge clk);
        chk("small_ready", sif.cmd_ready, 1'b1);
        sif.cmd_ir = 2'b10; sif.cmd_dr = 4'b1011; sif.cmd_valid = 1'b1;
        @(posedge clk); #1 sif.cmd_valid = 1'b0;
        lat = 0;
        while (!sif.rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("small_latency", lat, SLAT);
        chk("small_rsp", sif.rsp_dr, 4'b0110);
        chk("small_ir_out", sif.rsp_ir_out, 2'b01);
        chk("small_ir_in", sif.vji_ir_in, 2'b10);
        chk("small_target", tgt_s, 4'b1011);
        @(posedge clk); #1;
        chk("small_consumed", {sif.rsp_valid, sif.cmd_ready}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
